// File: rtl/div_share_sequencer_if.sv
// Handshake bundle between N requesters / one result consumer and the shared divider.
// master = client side (requesters + consumer), slave = div_share_sequencer.
interface div_share_sequencer_if #(
   parameter int N   = 4,
   parameter int W   = 4,
   parameter int IDW = $clog2(N)
);
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_dividend;
   logic [N*W-1:0] req_divisor;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [IDW-1:0] rsp_id;
   logic [W-1:0]   rsp_quotient;
   logic [W-1:0]   rsp_remainder;
   logic           rsp_dbz;
   logic           busy;

   modport master (
      output req_valid, req_dividend, req_divisor, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, busy
   );

   modport slave (
      input  req_valid, req_dividend, req_divisor, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, busy
   );
endinterface

// File: rtl/div_share_sequencer.sv
// Round-robin shared restoring divider, one quotient bit per clock.
// Define DIVSEQ_SHORTCUT_EN to resolve divisor 0/1 at accept time without iterating.
module div_share_sequencer #(
   parameter int N   = 4,
   parameter int W   = 4,
   parameter int IDW = $clog2(N)
) (
   input logic                  clk,
   input logic                  rst,
   div_share_sequencer_if.slave bus
);
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t         state_reg, state_next;
   logic [IDW-1:0] ptr_reg, ptr_next;
   logic [W-1:0]   dvd_reg;
   logic [W-1:0]   dsr_reg;
   logic [W-1:0]   rem_reg;
   logic [IDW-1:0] id_reg;
   logic           dbz_reg;
   logic [CW-1:0]  cnt_reg;

   logic [N-1:0]   grant;
   logic [IDW-1:0] grant_id;
   logic           grant_any;
   logic           accept;
   logic           shortcut;
   logic [W-1:0]   acc_dvd, acc_dsr;
   logic [W:0]     rem_shift;
   logic [W-1:0]   rem_step;
   logic           q_bit;

   // First valid requester at or after ptr, wrapping modulo N.
   always_comb begin
      int idx;
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_reg) + k) % N;
         if (!grant_any && bus.req_valid[idx]) begin
            grant_any   = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = IDW'(idx);
         end
      end
   end

   assign accept  = (state_reg == IDLE) && grant_any;
   assign acc_dvd = bus.req_dividend[int'(grant_id)*W +: W];
   assign acc_dsr = bus.req_divisor[int'(grant_id)*W +: W];

`ifdef DIVSEQ_SHORTCUT_EN
   assign shortcut = (acc_dsr <= W'(1));
`else
   assign shortcut = 1'b0;
`endif

   // One restoring step: bring in the next dividend bit, subtract if it fits.
   always_comb begin
      rem_shift = {rem_reg, dvd_reg[W-1]};
      q_bit     = (rem_shift >= {1'b0, dsr_reg});
      rem_step  = q_bit ? W'(rem_shift - {1'b0, dsr_reg}) : rem_shift[W-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         IDLE: begin
            if (grant_any) begin
               ptr_next   = (grant_id == IDW'(N-1)) ? '0 : grant_id + 1'b1;
               state_next = shortcut ? RESP : CALC;
            end
         end
         CALC: if (cnt_reg == '0) state_next = RESP;
         RESP: if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Quotient bits shift into dvd_reg as dividend bits shift out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dvd_reg <= '0;
         dsr_reg <= '0;
         rem_reg <= '0;
         id_reg  <= '0;
         dbz_reg <= 1'b0;
         cnt_reg <= '0;
      end else begin
         if (accept) begin
            id_reg  <= grant_id;
            dsr_reg <= acc_dsr;
            dbz_reg <= (acc_dsr == '0);
            cnt_reg <= CW'(W-1);
            dvd_reg <= acc_dvd;
            rem_reg <= '0;
            if (shortcut && acc_dsr == '0) begin
               dvd_reg <= '1;
               rem_reg <= acc_dvd;
            end
         end else if (state_reg == CALC) begin
            rem_reg <= rem_step;
            dvd_reg <= {dvd_reg[W-2:0], q_bit};
            cnt_reg <= cnt_reg - 1'b1;
         end
      end
   end

   // Results only appear while RESP is held, so reset forces every output low at once.
   assign bus.req_ready     = (rst && state_reg == IDLE) ? grant : '0;
   assign bus.rsp_valid     = (state_reg == RESP);
   assign bus.rsp_id        = bus.rsp_valid ? id_reg  : '0;
   assign bus.rsp_quotient  = bus.rsp_valid ? dvd_reg : '0;
   assign bus.rsp_remainder = bus.rsp_valid ? rem_reg : '0;
   assign bus.rsp_dbz       = bus.rsp_valid && dbz_reg;
   assign bus.busy          = (state_reg != IDLE);
endmodule
